// File: rtl/kamus_pkg.sv
// Shared types and constants for the kamus-v front end.
package kamus_pkg;

  localparam int unsigned XLEN = 32;

  // Control-unit decision on how the next PC is formed.
  typedef enum logic [1:0] {
    PC4_ST = 2'd0,
    B_ST   = 2'd1,
    J_ST   = 2'd2
  } instr_addr_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } fetch_state_t;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/kamus_next_pc.sv
// Redirect decision and word-aligned target for resolved jumps/branches.
module kamus_next_pc
  import kamus_pkg::*;
(
  input  logic              redirect_valid,
  input  instr_addr_state_t instr_addr_state,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   target_addr,
  output logic              take_c,
  output logic [XLEN-1:0]   target_c
);

  always_comb begin
    take_c   = 1'b0;
    target_c = target_addr & ~XLEN'(32'h3);
    if (redirect_valid) begin
      take_c = (instr_addr_state == J_ST) ||
               ((instr_addr_state == B_ST) && branch_taken);
    end
  end

endmodule

// File: rtl/kamus_fetch.sv
// Instruction fetch: PC owner, single-outstanding L1I requester, one-entry decode buffer.
module kamus_fetch
  import kamus_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              redirect_valid_i,
  input  instr_addr_state_t instr_addr_state_i,
  input  logic              branch_taken_i,
  input  logic [XLEN-1:0]   target_addr_i,
  output logic              l1i_req_o,
  output logic [XLEN-1:0]   l1i_addr_o,
  input  logic              l1i_gnt_i,
  input  logic              l1i_rvalid_i,
  input  logic [XLEN-1:0]   l1i_rdata_i,
  output logic              instr_valid_o,
  output logic [XLEN-1:0]   instr_o,
  output logic [XLEN-1:0]   instr_pc_o,
  input  logic              instr_ready_i
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc, pc_n, pending_pc, pending_pc_n;
  logic            pend, pend_n, kill, kill_n;
  logic            req, req_n, valid, valid_n;
  logic [XLEN-1:0] addr, addr_n, instr, instr_n, ipc, ipc_n;
  logic            take_c;
  logic [XLEN-1:0] target_c;

  kamus_next_pc u_next_pc (
    .redirect_valid   (redirect_valid_i),
    .instr_addr_state (instr_addr_state_i),
    .branch_taken     (branch_taken_i),
    .target_addr      (target_addr_i),
    .take_c           (take_c),
    .target_c         (target_c)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pending_pc <= RESET_PC;
      pend       <= 1'b0;
      kill       <= 1'b0;
      req        <= 1'b0;
      addr       <= RESET_PC;
      valid      <= 1'b0;
      instr      <= NOP_INSTR;
      ipc        <= RESET_PC;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      pending_pc <= pending_pc_n;
      pend       <= pend_n;
      kill       <= kill_n;
      req        <= req_n;
      addr       <= addr_n;
      valid      <= valid_n;
      instr      <= instr_n;
      ipc        <= ipc_n;
    end
  end

  // Next-state, PC and registered-output logic.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    pending_pc_n = pending_pc;
    pend_n       = pend;
    kill_n       = kill;
    req_n        = req;
    addr_n       = addr;
    valid_n      = valid;
    instr_n      = instr;
    ipc_n        = ipc;
    unique case (state)
      IDLE: begin
        if (take_c) pc_n = target_c;
        state_n = REQ;
        req_n   = 1'b1;
        addr_n  = pc_n;
      end
      REQ: begin
        // Address must hold until grant; a redirect here kills the granted fetch.
        if (l1i_gnt_i) begin
          state_n = WAIT;
          req_n   = 1'b0;
          if (take_c) begin
            kill_n = 1'b1;
            pc_n   = target_c;
            pend_n = 1'b0;
          end else if (pend) begin
            kill_n = 1'b1;
            pc_n   = pending_pc;
            pend_n = 1'b0;
          end
        end else if (take_c) begin
          pending_pc_n = target_c;
          pend_n       = 1'b1;
        end
      end
      WAIT: begin
        if (l1i_rvalid_i) begin
          if (kill || take_c) begin
            if (take_c) pc_n = target_c;
            kill_n  = 1'b0;
            state_n = REQ;
            req_n   = 1'b1;
            addr_n  = pc_n;
          end else begin
            instr_n = l1i_rdata_i;
            ipc_n   = pc;
            valid_n = 1'b1;
            pc_n    = pc + XLEN'(4);
            state_n = FULL;
          end
        end else if (take_c) begin
          pc_n   = target_c;
          kill_n = 1'b1;
        end
      end
      FULL: begin
        if (take_c || instr_ready_i) begin
          if (take_c) pc_n = target_c;
          valid_n = 1'b0;
          state_n = REQ;
          req_n   = 1'b1;
          addr_n  = pc_n;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign l1i_req_o     = req;
  assign l1i_addr_o    = addr;
  assign instr_valid_o = valid;
  assign instr_o       = instr;
  assign instr_pc_o    = ipc;

endmodule

// File: doc/kamus_fetch.md
# kamus_fetch

Instruction fetch unit for kamus-v: owns the program counter, issues single-outstanding requests to the L1 instruction cache, and hands fetched instructions to decode through a valid/ready handshake. It is the consumer of the control unit's `instr_addr_state` decision. Execute reports resolved jumps and branches back here, and the PC is redirected and any stale fetches are discarded.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.

Ports:
- `clk_i`  in  1  core clock
- `rst_ni`  in  1  asynchronous, active-low reset
- `redirect_valid_i`  in  1  execute resolved a control-flow instruction this cycle
- `instr_addr_state_i`  in  `instr_addr_state_t`  `PC4_ST`/`B_ST`/`J_ST` for that instruction
- `branch_taken_i`  in  1  branch condition result (used only with `B_ST`)
- `target_addr_i`  in  32  jump/branch target from the ALU
- `l1i_req_o`  out  1  fetch request
- `l1i_addr_o`  out  32  fetch address, word aligned
- `l1i_gnt_i`  in  1  request accepted
- `l1i_rvalid_i`  in  1  response data valid
- `l1i_rdata_i`  in  32  fetched instruction
- `instr_valid_o`  out  1  instruction available to decode
- `instr_o`  out  32  instruction word
- `instr_pc_o`  out  32  PC of `instr_o`
- `instr_ready_i`  in  1  decode accepts `instr_o`

## Operation
- **Redirect decision.** The redirect is taken when `redirect_valid_i` is high and either `instr_addr_state_i==J_ST`, or `instr_addr_state_i==B_ST` with `branch_taken_i` high.
  - `PC4_ST`, or `B_ST` not taken, is a no-op.
  - New PC is `{target_addr_i[31:2],2'b00}`.
- **FSM states:**
  - `IDLE`: reset state. Goes to `REQ` the next cycle.
  - `REQ`: `l1i_req_o=1`, `l1i_addr_o=pc`. On `l1i_gnt_i`, goes to `WAIT`.
  - `WAIT`: waits for `l1i_rvalid_i`.
    - On rvalid with the kill flag clear: the output buffer is written with `l1i_rdata_i` and the fetched PC, `pc<=pc+4`, and the FSM goes to `FULL`.
    - On rvalid with the kill flag set: data is dropped, kill is cleared, and the FSM goes to `REQ`.
  - `FULL`: `instr_valid_o=1`. On `instr_ready_i`, the buffer is cleared and the FSM goes to `REQ`.
- **Address stability.** `l1i_addr_o` and `l1i_req_o` stay stable in `REQ` until gnt.
  - A redirect in `REQ` without gnt stores the target in `pending_pc` and sets `pend`.
  - On gnt, kill is set and the FSM goes to `WAIT`. The next `REQ` uses `pending_pc`.
- **Redirect in `WAIT`:** `pc<=target`, kill set.
- **Redirect in `FULL`:** buffer flushed (`instr_valid_o` low next cycle), `pc<=target`, FSM goes to `REQ`. Redirect beats `instr_ready_i` in the same cycle.
- **Redirect in `IDLE`:** `pc<=target`.
- **Single outstanding.** At most one request is outstanding. `l1i_rvalid_i` outside `WAIT` is ignored.
- **PC arithmetic.** Modulo 2^32: `32'hFFFF_FFFC+4` wraps to 0.

## Timing
- **Reset values:** `l1i_req_o=0`, `l1i_addr_o=RESET_PC`, `instr_valid_o=0`, `instr_o=32'h0000_0013` (NOP), `instr_pc_o=RESET_PC`, `pc=RESET_PC`, kill/pend=0, state `IDLE`.
- **First request.** First `l1i_req_o` is asserted 1 cycle after `rst_ni` rises.
- **Zero-wait memory** (gnt with req, rvalid next cycle): `instr_valid_o` rises 2 cycles after the request cycle. Sustained throughput is one instruction per 3 cycles with decode always ready.
- **Handshake.** `instr_o`/`instr_pc_o` stay stable while `instr_valid_o=1` and `instr_ready_i=0`.
- **Redirect latency.** The first request to the target appears:
  - 1 cycle after the redirect from `FULL` or `IDLE`;
  - the cycle after the killed rvalid from `WAIT`.
- **Reset mid-fetch.** Reset is asynchronous: all state returns to reset values immediately. A late rvalid from the aborted request is ignored.

## Structure
- `kamus_pkg` holds:
  - `instr_addr_state_t`, already shared with the control unit;
  - new `fetch_state_t` (`IDLE`, `REQ`, `WAIT`, `FULL`);
  - `NOP_INSTR` constant.
- Sub-module `kamus_next_pc`: combinational redirect decision and aligned target computation. The FSM and buffer live in `kamus_fetch`.

## Test plan
- **Reset and sequential fetch.** Release reset with zero-wait memory returning `32'h00000013` -> requests at addresses 0, 4, 8. `instr_pc_o` follows 0, 4, 8, one instruction every 3 cycles.
- **Decode backpressure.** `instr_ready_i=0` for 5 cycles in `FULL` -> `instr_o` stable, no new `l1i_req_o`. After ready, next request to `pc+4`.
- **Jump in `WAIT`.** Redirect `J_ST`, target `32'h0000_0103` while waiting 3 cycles for rvalid -> returning data dropped, next request address `32'h0000_0100`, `instr_valid_o` never shows the stale word.
- **Branch decisions.** Redirect `B_ST`, taken=0, target `0x200` -> no change. Taken=1 -> next request `0x200`, buffered instruction flushed even with `instr_ready_i=1` the same cycle.
- **Redirect during stalled `REQ`.** Redirect while gnt is held low for 4 cycles -> `l1i_addr_o` unchanged until gnt, response killed, following request uses the target.
- **Reset and wrap.** Assert `rst_ni` low mid-`WAIT` -> all outputs at reset values asynchronously, late rvalid ignored. Separately, a fetch at `0xFFFF_FFFC` is followed by a fetch at 0.
